// File: rtl/sdram_port_arbiter.sv
// Two-requester arbiter for the SDRAM controller Avalon-MM port, with in-order read tag tracking.
// Optional build macro SDRAM_ARB_FIXED_PRIO_EN: rq0 always wins ties (rq1 may starve).
module sdram_port_arbiter #(
  parameter int unsigned AW       = 24,
  parameter int unsigned DW       = 16,
  parameter int unsigned BEW      = 2,
  parameter int unsigned MAX_PEND = 4
) (
  input  logic                             clk_clk,
  input  logic                             reset_reset_n,
  input  logic [AW-1:0]                    rq0_address,
  input  logic                             rq0_read,
  input  logic                             rq0_write,
  input  logic [DW-1:0]                    rq0_writedata,
  input  logic [BEW-1:0]                   rq0_byteenable,
  output logic                             rq0_waitrequest,
  output logic [DW-1:0]                    rq0_readdata,
  output logic                             rq0_readdatavalid,
  input  logic [AW-1:0]                    rq1_address,
  input  logic                             rq1_read,
  input  logic                             rq1_write,
  input  logic [DW-1:0]                    rq1_writedata,
  input  logic [BEW-1:0]                   rq1_byteenable,
  output logic                             rq1_waitrequest,
  output logic [DW-1:0]                    rq1_readdata,
  output logic                             rq1_readdatavalid,
  output logic [AW-1:0]                    sd_address,
  output logic                             sd_read,
  output logic                             sd_write,
  output logic [DW-1:0]                    sd_writedata,
  output logic [BEW-1:0]                   sd_byteenable,
  input  logic                             sd_waitrequest,
  input  logic [DW-1:0]                    sd_readdata,
  input  logic                             sd_readdatavalid,
  output logic [$clog2(MAX_PEND):0]        pend_count,
  output logic                             orphan_err
);

  localparam int unsigned PW = $clog2(MAX_PEND);
  localparam int unsigned CW = PW + 1;

  logic                r_last_grant;
  logic [MAX_PEND-1:0] r_tag;
  logic [PW-1:0]       r_wptr;
  logic [PW-1:0]       r_rptr;
  logic [CW-1:0]       r_pend;
  logic                r_orphan;

  logic w_rd_avail;
  logic w_elig0;
  logic w_elig1;
  logic w_sel_vld;
  logic w_sel_id;
  logic w_issue;
  logic w_push;
  logic w_pop;
  logic w_empty;
  logic w_head;

  // Eligibility uses the registered count, so a same-cycle return never unblocks a read.
  assign w_rd_avail = (r_pend < CW'(MAX_PEND));
  assign w_elig0    = rq0_read ? w_rd_avail : rq0_write;
  assign w_elig1    = rq1_read ? w_rd_avail : rq1_write;

  // Selection; nothing is selected while reset is held.
  always_comb begin
    w_sel_vld = 1'b0;
    w_sel_id  = 1'b0;
    if (reset_reset_n) begin
      if (w_elig0 && w_elig1) begin
        w_sel_vld = 1'b1;
`ifdef SDRAM_ARB_FIXED_PRIO_EN
        w_sel_id  = 1'b0;
`else
        w_sel_id  = ~r_last_grant;
`endif
      end else if (w_elig0) begin
        w_sel_vld = 1'b1;
        w_sel_id  = 1'b0;
      end else if (w_elig1) begin
        w_sel_vld = 1'b1;
        w_sel_id  = 1'b1;
      end
    end
  end

  // Master-side mux; a read+write request is treated as a read.
  always_comb begin
    sd_address    = '0;
    sd_read       = 1'b0;
    sd_write      = 1'b0;
    sd_writedata  = '0;
    sd_byteenable = '0;
    if (w_sel_vld) begin
      if (w_sel_id) begin
        sd_address    = rq1_address;
        sd_read       = rq1_read;
        sd_write      = rq1_write & ~rq1_read;
        sd_writedata  = rq1_writedata;
        sd_byteenable = rq1_byteenable;
      end else begin
        sd_address    = rq0_address;
        sd_read       = rq0_read;
        sd_write      = rq0_write & ~rq0_read;
        sd_writedata  = rq0_writedata;
        sd_byteenable = rq0_byteenable;
      end
    end
  end

  assign w_issue = w_sel_vld & ~sd_waitrequest;
  assign w_push  = w_issue & sd_read;
  assign w_empty = (r_pend == '0);
  assign w_pop   = reset_reset_n & sd_readdatavalid & ~w_empty;
  assign w_head  = r_tag[r_rptr];

  assign rq0_waitrequest   = ~(w_issue & ~w_sel_id);
  assign rq1_waitrequest   = ~(w_issue &  w_sel_id);
  assign rq0_readdata      = sd_readdata;
  assign rq1_readdata      = sd_readdata;
  assign rq0_readdatavalid = w_pop & ~w_head;
  assign rq1_readdatavalid = w_pop &  w_head;
  assign pend_count        = r_pend;
  assign orphan_err        = r_orphan;

  // Grant history, tag FIFO and sticky orphan flag.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      r_last_grant <= 1'b1;
      r_tag        <= '0;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_pend       <= '0;
      r_orphan     <= 1'b0;
    end else begin
      if (w_issue) begin
        r_last_grant <= w_sel_id;
      end
      if (w_push) begin
        r_tag[r_wptr] <= w_sel_id;
        r_wptr        <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_pend <= r_pend + CW'(1);
        2'b01:   r_pend <= r_pend - CW'(1);
        default: r_pend <= r_pend;
      endcase
      if (sd_readdatavalid && w_empty) begin
        r_orphan <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed self-checking bench for sdram_port_arbiter (default build; fixed-priority expectations under SDRAM_ARB_FIXED_PRIO_EN).
module tb_sdram_port_arbiter;

  localparam int unsigned AW  = 24;
  localparam int unsigned DW  = 16;
  localparam int unsigned BEW = 2;

  logic          clk_clk = 1'b0;
  logic          reset_reset_n;
  logic [AW-1:0] rq0_address, rq1_address;
  logic          rq0_read, rq1_read, rq0_write, rq1_write;
  logic [DW-1:0] rq0_writedata, rq1_writedata;
  logic [BEW-1:0] rq0_byteenable, rq1_byteenable;
  logic          rq0_waitrequest, rq1_waitrequest;
  logic [DW-1:0] rq0_readdata, rq1_readdata;
  logic          rq0_readdatavalid, rq1_readdatavalid;
  logic [AW-1:0] sd_address;
  logic          sd_read, sd_write;
  logic [DW-1:0] sd_writedata;
  logic [BEW-1:0] sd_byteenable;
  logic          sd_waitrequest;
  logic [DW-1:0] sd_readdata;
  logic          sd_readdatavalid;
  logic [2:0]    pend_count;
  logic          orphan_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_clk = ~clk_clk;

  sdram_port_arbiter #(.AW(AW), .DW(DW), .BEW(BEW), .MAX_PEND(4)) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
    .rq0_address(rq0_address), .rq0_read(rq0_read), .rq0_write(rq0_write),
    .rq0_writedata(rq0_writedata), .rq0_byteenable(rq0_byteenable),
    .rq0_waitrequest(rq0_waitrequest), .rq0_readdata(rq0_readdata),
    .rq0_readdatavalid(rq0_readdatavalid),
    .rq1_address(rq1_address), .rq1_read(rq1_read), .rq1_write(rq1_write),
    .rq1_writedata(rq1_writedata), .rq1_byteenable(rq1_byteenable),
    .rq1_waitrequest(rq1_waitrequest), .rq1_readdata(rq1_readdata),
    .rq1_readdatavalid(rq1_readdatavalid),
    .sd_address(sd_address), .sd_read(sd_read), .sd_write(sd_write),
    .sd_writedata(sd_writedata), .sd_byteenable(sd_byteenable),
    .sd_waitrequest(sd_waitrequest), .sd_readdata(sd_readdata),
    .sd_readdatavalid(sd_readdatavalid),
    .pend_count(pend_count), .orphan_err(orphan_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance past the next rising edge; inputs change here, outputs sampled at the falling edge.
  task automatic step();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk_clk);
  endtask

  task automatic idle_inputs();
    rq0_read = 1'b0; rq0_write = 1'b0; rq1_read = 1'b0; rq1_write = 1'b0;
    sd_readdatavalid = 1'b0; sd_waitrequest = 1'b0;
  endtask

  logic [AW-1:0] exp_addr [4];
  logic [DW-1:0] exp_data [3];

  initial begin
    reset_reset_n = 1'b0;
    rq0_address = '0; rq1_address = '0;
    rq0_writedata = 16'h1111; rq1_writedata = 16'h2222;
    rq0_byteenable = 2'b11; rq1_byteenable = 2'b01;
    sd_readdata = '0;
    idle_inputs();

    // Reset held with a pending rq0 read request
    rq0_read = 1'b1; rq0_address = 24'h000055;
    step(); step(); sample();
    check("rst_sd_read", 32'(sd_read), 32'd0);
    check("rst_wr0", 32'(rq0_waitrequest), 32'd1);
    step();
    reset_reset_n = 1'b1; rq0_read = 1'b0;
    sample();
    check("idle_pend", 32'(pend_count), 32'd0);
    check("idle_orphan", 32'(orphan_err), 32'd0);
    check("idle_sd_read", 32'(sd_read), 32'd0);
    check("idle_sd_write", 32'(sd_write), 32'd0);
    check("idle_wr0", 32'(rq0_waitrequest), 32'd1);
    check("idle_wr1", 32'(rq1_waitrequest), 32'd1);

    // Alternating write ties
    step();
    rq0_write = 1'b1; rq0_address = 24'h000010;
    rq1_write = 1'b1; rq1_address = 24'h000020;
`ifdef SDRAM_ARB_FIXED_PRIO_EN
    exp_addr = '{24'h10, 24'h10, 24'h10, 24'h10};
`else
    exp_addr = '{24'h10, 24'h20, 24'h10, 24'h20};
`endif
    for (int i = 0; i < 4; i++) begin
      sample();
      check("tie_addr", 32'(sd_address), 32'(exp_addr[i]));
      check("tie_write", 32'(sd_write), 32'd1);
      check("tie_wdata", 32'(sd_writedata), (exp_addr[i] == 24'h10) ? 32'h1111 : 32'h2222);
      check("tie_wr0", 32'(rq0_waitrequest), (exp_addr[i] == 24'h10) ? 32'd0 : 32'd1);
      check("tie_wr1", 32'(rq1_waitrequest), (exp_addr[i] == 24'h20) ? 32'd0 : 32'd1);
      step();
    end
    idle_inputs();

    // Read tagging: rq0, rq1, rq0, then in-order returns
    rq0_read = 1'b1; rq0_address = 24'h000100;
    sample();
    check("rd0_sd_read", 32'(sd_read), 32'd1);
    check("rd0_addr", 32'(sd_address), 32'h100);
    check("rd0_wr0", 32'(rq0_waitrequest), 32'd0);
    step();
    rq0_read = 1'b0; rq1_read = 1'b1; rq1_address = 24'h000200;
    sample();
    check("rd1_addr", 32'(sd_address), 32'h200);
    check("rd1_wr1", 32'(rq1_waitrequest), 32'd0);
    step();
    rq1_read = 1'b0; rq0_read = 1'b1; rq0_address = 24'h000300;
    sample();
    check("rd2_pend", 32'(pend_count), 32'd2);
    step();
    rq0_read = 1'b0;
    sample();
    check("rd_pend_peak", 32'(pend_count), 32'd3);
    step(); step();
    exp_data = '{16'hAAAA, 16'hBBBB, 16'hCCCC};
    for (int i = 0; i < 3; i++) begin
      sd_readdatavalid = 1'b1; sd_readdata = exp_data[i];
      sample();
      check("ret_rdv0", 32'(rq0_readdatavalid), (i == 1) ? 32'd0 : 32'd1);
      check("ret_rdv1", 32'(rq1_readdatavalid), (i == 1) ? 32'd1 : 32'd0);
      check("ret_data", (i == 1) ? 32'(rq1_readdata) : 32'(rq0_readdata), 32'(exp_data[i]));
      step();
    end
    sd_readdatavalid = 1'b0;
    sample();
    check("ret_pend_zero", 32'(pend_count), 32'd0);

    // Full FIFO
    step();
    rq0_read = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rq0_address = 24'h000400 + 24'(i);
      sample();
      check("fill_pend", 32'(pend_count), 32'(i));
      check("fill_wr0", 32'(rq0_waitrequest), 32'd0);
      step();
    end
    rq0_address = 24'h000500; rq1_write = 1'b1; rq1_address = 24'h000600;
    sample();
    check("full_pend", 32'(pend_count), 32'd4);
    check("full_wr0", 32'(rq0_waitrequest), 32'd1);
    check("full_wr1", 32'(rq1_waitrequest), 32'd0);
    check("full_addr", 32'(sd_address), 32'h600);
    check("full_sd_read", 32'(sd_read), 32'd0);
    step();
    rq1_write = 1'b0; sd_readdatavalid = 1'b1; sd_readdata = 16'h1234;
    sample();
    check("full_ret_block", 32'(rq0_waitrequest), 32'd1);
    check("full_ret_rdv0", 32'(rq0_readdatavalid), 32'd1);
    step();
    sd_readdatavalid = 1'b0;
    sample();
    check("after_ret_pend", 32'(pend_count), 32'd3);
    check("after_ret_wr0", 32'(rq0_waitrequest), 32'd0);
    check("after_ret_addr", 32'(sd_address), 32'h500);
    step();
    rq0_read = 1'b0; sd_readdatavalid = 1'b1;
    step(); step();
    rq0_read = 1'b1; rq0_address = 24'h000700;
    sample();
    check("same_pend_before", 32'(pend_count), 32'd2);
    check("same_wr0", 32'(rq0_waitrequest), 32'd0);
    step();
    rq0_read = 1'b0; sd_readdatavalid = 1'b0;
    sample();
    check("same_pend_after", 32'(pend_count), 32'd2);
    step();
    sd_readdatavalid = 1'b1;
    step(); step();
    sd_readdatavalid = 1'b0;
    sample();
    check("drain_pend", 32'(pend_count), 32'd0);
    check("drain_orphan", 32'(orphan_err), 32'd0);

    // Stall on an rq1 write; last grant was rq0 so a competing rq0 write must not steal the slot
    step();
    sd_waitrequest = 1'b1;
    rq1_write = 1'b1; rq1_address = 24'h0ABCDE; rq1_writedata = 16'h5A5A;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
    rq0_write = 1'b1; rq0_address = 24'h000111;
`endif
    for (int i = 0; i < 5; i++) begin
      sample();
      check("stall_addr", 32'(sd_address), 32'h0ABCDE);
      check("stall_wdata", 32'(sd_writedata), 32'h5A5A);
      check("stall_wr1", 32'(rq1_waitrequest), 32'd1);
      step();
    end
    sd_waitrequest = 1'b0;
    sample();
    check("stall_issue_wr1", 32'(rq1_waitrequest), 32'd0);
    check("stall_issue_addr", 32'(sd_address), 32'h0ABCDE);
    step();
    rq1_write = 1'b0;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
    sample();
    check("post_stall_wr0", 32'(rq0_waitrequest), 32'd0);
    check("post_stall_addr", 32'(sd_address), 32'h000111);
    step();
`endif
    idle_inputs();

    // Orphan returns after a mid-flight reset
    rq0_read = 1'b1; rq0_address = 24'h000800;
    step(); step();
    rq0_read = 1'b0;
    sample();
    check("orph_pend2", 32'(pend_count), 32'd2);
    step();
    reset_reset_n = 1'b0;
    step();
    reset_reset_n = 1'b1;
    sample();
    check("orph_pend_rst", 32'(pend_count), 32'd0);
    step();
    sd_readdatavalid = 1'b1; sd_readdata = 16'hDEAD;
    sample();
    check("orph_rdv0_a", 32'(rq0_readdatavalid), 32'd0);
    check("orph_rdv1_a", 32'(rq1_readdatavalid), 32'd0);
    check("orph_flag_pre", 32'(orphan_err), 32'd0);
    step();
    sd_readdata = 16'hBEEF;
    sample();
    check("orph_flag", 32'(orphan_err), 32'd1);
    check("orph_rdv0_b", 32'(rq0_readdatavalid), 32'd0);
    check("orph_rdv1_b", 32'(rq1_readdatavalid), 32'd0);
    step();
    sd_readdatavalid = 1'b0;
    step();
    sample();
    check("orph_sticky", 32'(orphan_err), 32'd1);
    check("orph_pend", 32'(pend_count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Shares the single Avalon-MM port of the platform SDRAM controller (16-bit data, 2 byte lanes, 24-bit halfword address) between two requesters, e.g. the Nios data master and a CORDIC stream engine.
- Grants one transaction per cycle, round-robin by default.
- Tracks outstanding pipelined reads in an in-order tag FIFO so that each readdatavalid returns to the requester that issued the read.
- Sits between the requester masters and the SDRAM controller slave inside the platform.

Parameters:
- AW, 24, address width (halfword address).
- DW, 16, data width.
- BEW, 2, byteenable width (DW/8).
- MAX_PEND, 4, maximum outstanding reads; tag FIFO depth, power of two, 2..16.

Ports:
- clk_clk  in  1  system clock; all state updates on rising edge.
- reset_reset_n  in  1  synchronous, active-low reset.
- rq0_address / rq1_address  in  AW  requester n address.
- rq0_read / rq1_read  in  1  read request.
- rq0_write / rq1_write  in  1  write request.
- rq0_writedata / rq1_writedata  in  DW  write data.
- rq0_byteenable / rq1_byteenable  in  BEW  byte lanes.
- rq0_waitrequest / rq1_waitrequest  out  1  high = request not accepted this cycle.
- rq0_readdata / rq1_readdata  out  DW  read return data.
- rq0_readdatavalid / rq1_readdatavalid  out  1  read return strobe.
- sd_address  out  AW  to SDRAM controller.
- sd_read, sd_write  out  1  to SDRAM controller.
- sd_writedata  out  DW  to SDRAM controller.
- sd_byteenable  out  BEW  to SDRAM controller.
- sd_waitrequest  in  1  controller stall.
- sd_readdata  in  DW  controller read data.
- sd_readdatavalid  in  1  controller read strobe.
- pend_count  out  log2(MAX_PEND)+1  outstanding reads.
- orphan_err  out  1  sticky: readdatavalid arrived with no pending tag.

Behaviour:
- Reset (reset_reset_n low at an edge):
  - last_grant <= 1, so rq0 wins the first tie.
  - Tag FIFO emptied; pend_count <= 0; orphan_err <= 0.
  - While reset is held low, sd_read, sd_write, rq*_readdatavalid and the selection are all forced 0, and rq*_waitrequest is forced 1.
- Request: a requester requests when read|write is high. Read and write both high is illegal; treat it as a read.
- Eligibility: a read is eligible only when pend_count < MAX_PEND. A write is always eligible.
- Selection (combinational):
  - Only eligible requests are considered.
  - Exactly one eligible: select it.
  - Both eligible: select the requester != last_grant.
- Master drive: sd_address, sd_writedata, sd_byteenable, sd_read and sd_write come from the selected requester. All are 0 when none is selected.
- Issue: happens when a requester is selected and sd_waitrequest = 0 in the same cycle. At that edge:
  - last_grant <= selected.
  - For a read, push the requester id into the tag FIFO.
- Waitrequest: rq_n_waitrequest = ~(selected==n & ~sd_waitrequest). It is high for a non-selected or stalled requester, including when idle. Requesters must hold their signals stable while waitrequest is high.
- Starvation: no requester waits more than one issued transaction of the other, given continuous eligibility.
- Read return:
  - When sd_readdatavalid is high and the FIFO is non-empty, pop the head id.
  - Assert that requester's readdatavalid in the same cycle (combinational from the FIFO head).
  - Route sd_readdata to both rq*_readdata unchanged.
  - Returns are strictly in issue order.
- Simultaneous read issue and return in one cycle: push and pop both happen; pend_count is unchanged. A read issue at pend_count==MAX_PEND with a same-cycle return is still blocked, because eligibility uses the registered count.
- Orphan return: sd_readdatavalid with an empty FIFO sets orphan_err. The data is dropped and both readdatavalid stay low. orphan_err clears only on reset.
- Writes are fire-and-forget and do not touch the FIFO. A write may issue while reads are pending.
- Latency: zero added cycles on the command path; zero on the return path.
- Pointer wrap: FIFO read/write pointers are log2(MAX_PEND) bits and wrap modulo MAX_PEND. Full/empty is derived from pend_count.

Optional Feature:
- Macro: SDRAM_ARB_FIXED_PRIO_EN.
- Defined: when both requesters are eligible, rq0 is always selected; last_grant is still updated but ignored. rq1 can starve; this is intended for a real-time CORDIC stream attached to rq0.
- Undefined: round-robin as specified above.

Test Plan:
- Reset then idle:
  - Check pend_count=0, orphan_err=0, sd_read=sd_write=0, rq0/rq1_waitrequest=1.
  - Hold reset low with rq0_read high -> sd_read stays 0 and rq0_waitrequest stays 1.
- Alternating ties: rq0 and rq1 both write continuously, sd_waitrequest=0, rq0 addr 0x000010, rq1 addr 0x000020.
  - Expect sd_address sequence 0x10,0x20,0x10,0x20; each rq waitrequest low every other cycle.
  - With SDRAM_ARB_FIXED_PRIO_EN: always 0x10, rq1_waitrequest stuck 1.
- Read tagging: rq0 reads 0x100, rq1 reads 0x200, rq0 reads 0x300; controller returns 0xAAAA, 0xBBBB, 0xCCCC three cycles later.
  - Expect rq0_readdatavalid with 0xAAAA, then rq1 with 0xBBBB, then rq0 with 0xCCCC.
  - pend_count peaks at 3 and returns to 0.
- Full FIFO: issue 4 reads with no return.
  - A 5th read keeps waitrequest=1 while a rq1 write still issues.
  - One return -> pend_count=3 and the 5th read issues next cycle.
  - Same-cycle issue and return at pend_count=2 -> pend_count stays 2.
- Stall: sd_waitrequest=1 for 5 cycles during an rq1 write.
  - sd_address and sd_writedata are held stable, rq1_waitrequest=1, last_grant unchanged.
  - The write issues on the first cycle with sd_waitrequest=0.
- Orphan and reset mid-flight: issue 2 reads, pulse reset_reset_n low for 1 cycle, then controller returns 2 words.
  - Expect no rq readdatavalid, orphan_err=1 after the first return, pend_count=0.
